stage_operand_feeder: RTL and testbench

STAGE_OPERAND_FEEDER -- requirements
Module: stage_operand_feeder

---
 rtl/stage_operand_feeder.sv | 143 ++++++++++++++
 tb/tb_stage_operand_feeder.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_operand_feeder.sv
// stage_operand_feeder: primes a beat FIFO, then streams one beat per step to a stage consumer.
// Define FEEDER_UNDERRUN_CNT_EN to build the saturating starvation counter behind underrun_cnt_o.
module stage_operand_feeder #(
    parameter int PARA          = 8,
    parameter int WIDTH         = 16,
    parameter int PARALLEL_SIZE = 2,
    parameter int DEPTH         = 16,
    parameter int PRIME_LEVEL   = 4
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic                                      start_i,
    input  logic                                      flush_i,
    input  logic [6:0][PARA-1:0]                      boundary_i,
    input  logic                                      in_valid_i,
    output logic                                      in_ready_o,
    input  logic [PARALLEL_SIZE-1:0][WIDTH-1:0]       in_operand_i,
    input  logic [PARALLEL_SIZE-1:0][WIDTH-1:0]       in_scale_i,
    output logic [6:0][PARA-1:0]                      stage_boundary_o,
    output logic                                      stage2_rst_o,
    output logic [PARALLEL_SIZE-1:0][WIDTH-1:0]       operand_o,
    output logic [PARALLEL_SIZE-1:0][WIDTH-1:0]       scale_o,
    output logic [PARALLEL_SIZE-1:0][WIDTH-1:0]       pos_o,
    output logic                                      out_valid_o,
    output logic [PARA:0]                             step_o,
    output logic                                      busy_o,
    output logic                                      done_o,
    output logic                                      underrun_o,
    output logic [PARA-1:0]                           underrun_cnt_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int BW = 2 * PARALLEL_SIZE * WIDTH;
    typedef enum logic [1:0] {IDLE, PRIME, RUN, DONE} state_t;
    state_t state_q, state_d;
    logic [BW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0] cnt_q, cnt_d;
    logic [6:0][PARA-1:0] bnd_q, bnd_d;
    logic [PARA:0] step_q, step_d;
    logic [PARALLEL_SIZE-1:0][WIDTH-1:0] opnd_q, opnd_d, scl_q, scl_d;
    logic vld_q, vld_d, done_q, done_d, srst_q, srst_d, unr_q, unr_d;
    logic push, pop, empty, last, emit, start_acc;
    assign in_ready_o = !cnt_q[AW];
    assign empty      = cnt_q == '0;
    assign push       = in_valid_i && in_ready_o && !flush_i;
    assign last       = step_q == {1'b0, bnd_q[6]};
    assign start_acc  = state_q == IDLE && start_i && !flush_i;
    // emit marks an edge that puts a step onto the outputs (first from PRIME, then each RUN step)
    assign emit = !flush_i && ((state_q == PRIME && cnt_q >= (AW+1)'(PRIME_LEVEL)) ||
                               (state_q == RUN && !last));
    assign pop  = emit && !empty;
    always_ff @(posedge clk_i)
        if (push) mem_q[wptr_q] <= {in_operand_i, in_scale_i};
    always_comb begin
        state_d = state_q;
        bnd_d   = bnd_q;
        step_d  = step_q;
        unr_d   = unr_q;
        opnd_d  = '0;
        scl_d   = '0;
        vld_d   = 1'b0;
        done_d  = 1'b0;
        srst_d  = 1'b1;
        wptr_d  = wptr_q + AW'(push);
        rptr_d  = rptr_q + AW'(pop);
        cnt_d   = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        case (state_q)
            IDLE:    if (start_acc) begin bnd_d = boundary_i; unr_d = 1'b0; state_d = PRIME; end
            PRIME:   if (emit) state_d = RUN;
            RUN:     if (last) begin state_d = DONE; done_d = 1'b1; end
            default: state_d = IDLE;
        endcase
        if (emit) begin
            srst_d = 1'b0;
            vld_d  = !empty;
            unr_d  = unr_q | empty;
            step_d = state_q == RUN ? step_q + 1'b1 : '0;
            if (!empty) {opnd_d, scl_d} = mem_q[rptr_q];
        end
        if (flush_i) begin
            state_d = IDLE;
            wptr_d  = '0;
            rptr_d  = '0;
            cnt_d   = '0;
            step_d  = '0;
            done_d  = 1'b0;
        end
    end
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            state_q <= IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            bnd_q   <= '0;
            step_q  <= '0;
            opnd_q  <= '0;
            scl_q   <= '0;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
            srst_q  <= 1'b1;
            unr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            bnd_q   <= bnd_d;
            step_q  <= step_d;
            opnd_q  <= opnd_d;
            scl_q   <= scl_d;
            vld_q   <= vld_d;
            done_q  <= done_d;
            srst_q  <= srst_d;
            unr_q   <= unr_d;
        end
    for (genvar i = 0; i < PARALLEL_SIZE; i++) begin : g_pos
        assign pos_o[i] = state_q == RUN ? WIDTH'(32'(step_q) * PARALLEL_SIZE + i) : '0;
    end
`ifdef FEEDER_UNDERRUN_CNT_EN
    logic [PARA-1:0] ucnt_q, ucnt_d;
    always_comb begin
        ucnt_d = ucnt_q;
        if (start_acc) ucnt_d = '0;
        else if (emit && empty && !(&ucnt_q)) ucnt_d = ucnt_q + 1'b1;
    end
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) ucnt_q <= '0;
        else ucnt_q <= ucnt_d;
    assign underrun_cnt_o = ucnt_q;
`else
    assign underrun_cnt_o = '0;
`endif
    assign stage_boundary_o = bnd_q;
    assign stage2_rst_o     = srst_q;
    assign operand_o        = opnd_q;
    assign scale_o          = scl_q;
    assign out_valid_o      = vld_q;
    assign step_o           = step_q;
    assign busy_o           = state_q == PRIME || state_q == RUN;
    assign done_o           = done_q;
    assign underrun_o       = unr_q;
endmodule

// File: tb/tb_stage_operand_feeder.sv
// tb_stage_operand_feeder: random beats checked against a queue model of the stream and run rules.
module tb_stage_operand_feeder;
    logic clk = 1'b0, rst_i = 1'b1, start_i = 1'b0, flush_i = 1'b0, in_valid_i = 1'b0;
    logic [6:0][7:0] boundary_i = '0, stage_boundary_o, exp_bnd = '0;
    logic [1:0][15:0] in_operand_i = '0, in_scale_i = '0, operand_o, scale_o, pos_o;
    logic in_ready_o, stage2_rst_o, out_valid_o, busy_o, done_o, underrun_o;
    logic [8:0] step_o;
    logic [7:0] underrun_cnt_o;
    logic [63:0] q[$];
    int n_chk = 0, n_fail = 0;

    stage_operand_feeder dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .flush_i(flush_i),
        .boundary_i(boundary_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_operand_i(in_operand_i), .in_scale_i(in_scale_i),
        .stage_boundary_o(stage_boundary_o), .stage2_rst_o(stage2_rst_o),
        .operand_o(operand_o), .scale_o(scale_o), .pos_o(pos_o), .out_valid_o(out_valid_o),
        .step_o(step_o), .busy_o(busy_o), .done_o(done_o), .underrun_o(underrun_o),
        .underrun_cnt_o(underrun_cnt_o)
    );

    always #5 clk = ~clk;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    task automatic rand_beat();
        in_operand_i = $urandom;
        in_scale_i   = $urandom;
    endtask

    task automatic push_beats(input int n);
        bit acc;
        for (int i = 0; i < n; i++) begin
            in_valid_i = 1'b1;
            rand_beat();
            acc = in_ready_o;
            @(negedge clk);
            if (acc) q.push_back({in_operand_i, in_scale_i});
        end
        in_valid_i = 1'b0;
    endtask

    task automatic start_run(input int b);
        for (int j = 0; j < 6; j++) boundary_i[j] = 8'($urandom);
        boundary_i[6] = 8'(b);
        exp_bnd = boundary_i;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        boundary_i = {$urandom, $urandom};
    endtask

    task automatic do_flush();
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        q.delete();
    endtask

    task automatic check_run(input int bnd, input bit feed, input int flush_at);
        int w = 0, bad = 0, ec;
        bit pend = 1'b0, ev;
        logic [63:0] pd = '0, ex;
        while (stage2_rst_o && w < 40) begin @(negedge clk); w++; end
        n_chk++;
        if (stage2_rst_o !== 1'b0) begin
            n_fail++; $display("FAIL run_start: stage2_rst_o=%b, expected 0 within 40 cycles", stage2_rst_o);
            return;
        end
        n_chk++;
        if (stage_boundary_o !== exp_bnd) begin
            n_fail++; $display("FAIL boundary_latch: got %h expected %h", stage_boundary_o, exp_bnd);
        end
        for (int k = 0; k <= bnd; k++) begin
            ev = q.size() != 0;
            ex = ev ? q.pop_front() : 64'd0;
            if (!ev) bad++;
            n_chk++;
            if ({out_valid_o, operand_o, scale_o} !== {ev, ex}) begin
                n_fail++; $display("FAIL beat k=%0d: got v=%b %h%h expected v=%b %h", k, out_valid_o, operand_o, scale_o, ev, ex);
            end
            n_chk++;
            if (step_o !== 9'(k)) begin
                n_fail++; $display("FAIL step k=%0d: got %0d expected %0d", k, step_o, k);
            end
            n_chk++;
            if (pos_o !== {16'(2*k+1), 16'(2*k)}) begin
                n_fail++; $display("FAIL pos k=%0d: got %h expected %h", k, pos_o, {16'(2*k+1), 16'(2*k)});
            end
            n_chk++;
            if ({stage2_rst_o, busy_o, done_o} !== 3'b010) begin
                n_fail++; $display("FAIL run_ctrl k=%0d: got rst/busy/done=%b expected 010", k, {stage2_rst_o, busy_o, done_o});
            end
            if (pend) q.push_back(pd);
            if (k == flush_at) begin
                flush_i = 1'b1;
                in_valid_i = 1'b1;
                rand_beat();
                @(negedge clk);
                flush_i = 1'b0;
                in_valid_i = 1'b0;
                q.delete();
                n_chk++;
                if ({out_valid_o, stage2_rst_o, busy_o, done_o} !== 4'b0100) begin
                    n_fail++; $display("FAIL flush_ctrl: got v/rst/busy/done=%b expected 0100", {out_valid_o, stage2_rst_o, busy_o, done_o});
                end
                return;
            end
            in_valid_i = feed;
            rand_beat();
            pend = feed && in_ready_o;
            pd = {in_operand_i, in_scale_i};
            @(negedge clk);
        end
        n_chk++;
        if ({done_o, out_valid_o, stage2_rst_o, busy_o} !== 4'b1010) begin
            n_fail++; $display("FAIL done_cycle: got done/v/rst/busy=%b expected 1010", {done_o, out_valid_o, stage2_rst_o, busy_o});
        end
        if (pend) q.push_back(pd);
        in_valid_i = 1'b0;
        n_chk++;
        if (underrun_o !== (bad != 0)) begin
            n_fail++; $display("FAIL underrun_flag: got %b expected %b", underrun_o, bad != 0);
        end
`ifdef FEEDER_UNDERRUN_CNT_EN
        ec = bad > 255 ? 255 : bad;
`else
        ec = 0;
`endif
        n_chk++;
        if (underrun_cnt_o !== 8'(ec)) begin
            n_fail++; $display("FAIL underrun_cnt: got %0d expected %0d", underrun_cnt_o, ec);
        end
        @(negedge clk);
        n_chk++;
        if ({done_o, busy_o} !== 2'b00) begin
            n_fail++; $display("FAIL done_pulse: got done/busy=%b expected 00", {done_o, busy_o});
        end
    endtask

    task automatic drain();
        int n = q.size();
        if (n >= 4) begin
            start_run(n - 1);
            check_run(n - 1, 1'b0, -1);
        end else do_flush();
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_chk++;
        if ({stage2_rst_o, out_valid_o, busy_o, done_o, underrun_o} !== 5'b10000) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 10000", {stage2_rst_o, out_valid_o, busy_o, done_o, underrun_o});
        end
        n_chk++;
        if ({operand_o, scale_o, pos_o, step_o, stage_boundary_o, underrun_cnt_o} !== '0) begin
            n_fail++; $display("FAIL reset_data: got nonzero outputs, expected all 0");
        end
        rst_i = 1'b0;
        @(negedge clk);
        n_chk++;
        if (in_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %b expected 1", in_ready_o);
        end
    endtask

    task automatic test_basic();
        push_beats(8);
        start_run(5);
        check_run(5, 1'b0, -1);
        push_beats(2);
        drain();
    endtask

    task automatic test_underrun();
        push_beats(4);
        start_run(7);
        check_run(7, 1'b0, -1);
    endtask

    task automatic test_prime();
        push_beats(2);
        start_run(3);
        for (int i = 0; i < 5; i++) begin
            n_chk++;
            if ({stage2_rst_o, busy_o, out_valid_o} !== 3'b110) begin
                n_fail++; $display("FAIL prime_hold: got rst/busy/v=%b expected 110", {stage2_rst_o, busy_o, out_valid_o});
            end
            @(negedge clk);
        end
        push_beats(2);
        check_run(3, 1'b0, -1);
    endtask

    task automatic test_full();
        push_beats(17);
        n_chk++;
        if (in_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL full_ready: got %b expected 0", in_ready_o);
        end
        start_run(15);
        check_run(15, 1'b1, -1);
        drain();
    endtask

    task automatic test_flush();
        push_beats(8);
        start_run(7);
        check_run(7, 1'b0, 3);
        push_beats(4);
        start_run(3);
        check_run(3, 1'b0, -1);
    endtask

    task automatic test_reset_mid_run();
        int w = 0;
        push_beats(6);
        start_run(5);
        while (stage2_rst_o && w < 40) begin @(negedge clk); w++; end
        start_i = 1'b1;
        boundary_i = {$urandom, $urandom};
        @(negedge clk);
        start_i = 1'b0;
        n_chk++;
        if ({step_o, stage_boundary_o, stage2_rst_o} !== {9'd1, exp_bnd, 1'b0}) begin
            n_fail++; $display("FAIL start_ignored: got step=%0d bnd=%h rst=%b expected 1 %h 0", step_o, stage_boundary_o, stage2_rst_o, exp_bnd);
        end
        #2 rst_i = 1'b1;
        #1;
        n_chk++;
        if ({out_valid_o, stage2_rst_o, busy_o, done_o} !== 4'b0100) begin
            n_fail++; $display("FAIL async_reset_ctrl: got v/rst/busy/done=%b expected 0100", {out_valid_o, stage2_rst_o, busy_o, done_o});
        end
        n_chk++;
        if ({operand_o, scale_o, pos_o, step_o, stage_boundary_o} !== '0) begin
            n_fail++; $display("FAIL async_reset_data: got nonzero outputs, expected all 0");
        end
        q.delete();
        @(negedge clk);
        rst_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_chk++;
            if ({done_o, in_ready_o, busy_o} !== 3'b010) begin
                n_fail++; $display("FAIL post_reset: got done/ready/busy=%b expected 010", {done_o, in_ready_o, busy_o});
            end
        end
    endtask

    task automatic test_long();
        push_beats(4);
        start_run(255);
        check_run(255, 1'b1, -1);
        drain();
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            int bnd;
            push_beats($urandom_range(4, 12));
            bnd = $urandom_range(0, 14);
            start_run(bnd);
            check_run(bnd, 1'($urandom_range(0, 1)), -1);
            drain();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_underrun();
        test_prime();
        test_full();
        test_flush();
        test_reset_mid_run();
        test_long();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
